pwm_fade_ctrl: RTL and testbench
================================

// Module: pwm_fade_ctrl
// PURPOSE
//  Upstream duty-cycle sequencer for the N-bit PWM generator. Drives its threshold bus.
//  Autonomous "breathing" ramp: up -> hold high -> down -> hold low, paced by an internal prescaler.
//  Manual override passes a static level (e.g. from slide switches) straight through.
// PARAMETERS
//  THRESHOLD_NBITS  4          width of level/threshold; must match the PWM block; MAX = 2**N-1
//  PRESCALE         1000000    clk cycles per ramp tick; >= 1 (1 = tick every cycle)
//  HOLD_TICKS       8          ticks dwelt at each end of the ramp; >= 1
// PORTS
//  clk           in   1  single clock, all logic rising-edge
//  rst_n         in   1  asynchronous, active-low reset
//  en            in   1  1 = run ramp sequence, 0 = freeze
//  manual        in   1  1 = override: level follows manual_level (priority over en)
//  manual_level  in   N  static level used when manual = 1
//  threshold     out  N  registered duty-cycle threshold to PWM
//  ramp_up       out  1  registered, 1 while state is RAMP_UP or HOLD_HIGH
//  peak          out  1  registered one-cycle pulse on entry to HOLD_HIGH
// BEHAVIOUR
//  Reset (async, any time incl. mid-ramp): state=IDLE, level=0, threshold=0, ramp_up=0, peak=0, tick/hold counters=0.
//  Prescaler: counts 0..PRESCALE-1 while en=1 and manual=0; tick=1 for the cycle at PRESCALE-1, then wraps to 0.
//   Cleared to 0 whenever en=0 or manual=1. Width $clog2(PRESCALE), min 1.
//  FSM states: IDLE, RAMP_UP, HOLD_HIGH, RAMP_DOWN, HOLD_LOW. Transitions evaluated only on tick unless noted.
//   manual=1 (any state, every cycle): level<=manual_level, state<=IDLE, hold cnt<=0.
//   en=0 & manual=0 (any state): state<=IDLE next cycle; level held (frozen).
//   IDLE & en=1 & manual=0: state<=RAMP_UP next cycle (no tick needed); level unchanged.
//   RAMP_UP on tick: if level==MAX -> HOLD_HIGH, no increment (no wrap), peak=1;
//    else level<=level+1; if level+1==MAX -> HOLD_HIGH, peak=1 same edge.
//   HOLD_HIGH on tick: hold_cnt+1; when hold_cnt==HOLD_TICKS-1 -> RAMP_DOWN, hold_cnt<=0.
//   RAMP_DOWN on tick: if level==0 -> HOLD_LOW (no wrap); else level<=level-1; if level-1==0 -> HOLD_LOW.
//   HOLD_LOW on tick: as HOLD_HIGH; terminal count -> RAMP_UP.
//  peak: high exactly one clk cycle per entry to HOLD_HIGH, 0 otherwise.
//  Level arithmetic saturating at 0 and MAX; never wraps.
//  Dwell at MAX/0 = HOLD_TICKS ticks; full period = 2*(MAX + HOLD_TICKS) ticks from 0.
//  Latency: threshold equals level register (0 extra cycles) when gamma is off; manual_level visible 1 cycle after sampling.
//  Inputs en/manual/manual_level are synchronous to clk; async sources are synchronized upstream.
// CONFIGURATION
//  Macro PWM_FADE_GAMMA_EN:
//   defined: threshold <= gamma(level), registered, 1 extra cycle latency after level;
//    gamma(L) = (L*L) >> N, except gamma(MAX) = MAX (guarantees 100% duty). 2N-bit product, truncated.
//    Applies to ramp and manual paths alike; gamma register resets to 0.
//   undefined: threshold is the level register directly; no multiplier inferred.
// TESTING  (N=4, PRESCALE=4, HOLD_TICKS=2, gamma off unless stated)
//  1 Reset: en=1 ramp running at level 7, pulse rst_n=0 -> threshold, ramp_up, peak = 0 immediately; after release with en=1 ramp restarts from 0.
//  2 Full cycle: en=1 from reset -> threshold 0->15 in 15 ticks (+1 per 4 clks), peak=1 for one cycle as 15 loads;
//    hold 8 clks at 15, 15->0 in 60 clks, hold 8 clks at 0, rises to 1 again; ramp_up 1 during up/hold-high only.
//  3 Freeze: drop en at threshold 7 -> stays 7, IDLE; re-assert en -> 8 appears 1+4 clks later.
//  4 Override: manual=1, manual_level=9, en=1 -> threshold 9 next cycle, held indefinitely; change to 3 -> 3 next cycle;
//    manual=0 -> ramp resumes upward from 3.
//  5 Saturation: manual_level=15 then manual=0 en=1 -> first tick enters HOLD_HIGH, threshold stays 15 (no wrap to 0), peak pulses.
//  6 PWM_FADE_GAMMA_EN: manual_level 8 -> 4, 15 -> 15, 3 -> 0, 12 -> 9, each 2 cycles after sampling.

Source files
------------

// File: rtl/pwm_fade_ctrl.sv
// Breathing duty-cycle sequencer feeding a PWM threshold bus, with a manual override.
// Optional macro PWM_FADE_GAMMA_EN adds a registered square-law gamma stage on the output.
module pwm_fade_ctrl #(
  parameter int THRESHOLD_NBITS = 4,
  parameter int PRESCALE        = 1000000,
  parameter int HOLD_TICKS      = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       en,
  input  logic                       manual,
  input  logic [THRESHOLD_NBITS-1:0] manual_level,
  output logic [THRESHOLD_NBITS-1:0] threshold,
  output logic                       ramp_up,
  output logic                       peak
);

  localparam int N  = THRESHOLD_NBITS;
  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int HW = (HOLD_TICKS > 1) ? $clog2(HOLD_TICKS) : 1;
  localparam logic [N-1:0]  MAX       = '1;
  localparam logic [N-1:0]  MAX_M1    = MAX - 1'b1;
  localparam logic [N-1:0]  ONE       = 1;
  localparam logic [PW-1:0] PS_LAST   = PW'(PRESCALE - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_TICKS - 1);

  typedef enum logic [2:0] {
    IDLE,
    RAMP_UP,
    HOLD_HIGH,
    RAMP_DOWN,
    HOLD_LOW
  } state_t;

  state_t        state, state_next;
  logic [N-1:0]  level, level_next;
  logic [HW-1:0] hold_cnt, hold_next;
  logic [PW-1:0] ps_cnt;
  logic          run, tick, peak_next;

  // Prescaler is held in IDLE so the first tick lands a full period after the ramp starts.
  assign run  = en && !manual && (state != IDLE);
  assign tick = run && (ps_cnt == PS_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ps_cnt <= '0;
    end else if (!run || tick) begin
      ps_cnt <= '0;
    end else begin
      ps_cnt <= ps_cnt + 1'b1;
    end
  end

  always_comb begin
    state_next = state;
    level_next = level;
    hold_next  = hold_cnt;
    peak_next  = 1'b0;
    if (manual) begin
      level_next = manual_level;
      state_next = IDLE;
      hold_next  = '0;
    end else if (!en) begin
      state_next = IDLE;
      hold_next  = '0;
    end else begin
      case (state)
        IDLE: state_next = RAMP_UP;
        RAMP_UP: begin
          if (tick) begin
            if (level == MAX) begin
              state_next = HOLD_HIGH;
              peak_next  = 1'b1;
            end else begin
              level_next = level + 1'b1;
              if (level == MAX_M1) begin
                state_next = HOLD_HIGH;
                peak_next  = 1'b1;
              end
            end
          end
        end
        HOLD_HIGH: begin
          if (tick) begin
            if (hold_cnt == HOLD_LAST) begin
              state_next = RAMP_DOWN;
              hold_next  = '0;
            end else begin
              hold_next = hold_cnt + 1'b1;
            end
          end
        end
        RAMP_DOWN: begin
          if (tick) begin
            if (level == '0) begin
              state_next = HOLD_LOW;
            end else begin
              level_next = level - 1'b1;
              if (level == ONE) state_next = HOLD_LOW;
            end
          end
        end
        HOLD_LOW: begin
          if (tick) begin
            if (hold_cnt == HOLD_LAST) begin
              state_next = RAMP_UP;
              hold_next  = '0;
            end else begin
              hold_next = hold_cnt + 1'b1;
            end
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      level    <= '0;
      hold_cnt <= '0;
      ramp_up  <= 1'b0;
      peak     <= 1'b0;
    end else begin
      state    <= state_next;
      level    <= level_next;
      hold_cnt <= hold_next;
      ramp_up  <= (state_next == RAMP_UP) || (state_next == HOLD_HIGH);
      peak     <= peak_next;
    end
  end

`ifdef PWM_FADE_GAMMA_EN
  logic [2*N-1:0] square;

  assign square = {{N{1'b0}}, level} * {{N{1'b0}}, level};

  // Full scale is forced so the top of the ramp still reaches 100% duty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      threshold <= '0;
    end else if (level == MAX) begin
      threshold <= MAX;
    end else begin
      threshold <= N'(square >> N);
    end
  end
`else
  assign threshold = level;
`endif

endmodule

// File: tb/tb_pwm_fade_ctrl.sv
// Directed self-checking bench for pwm_fade_ctrl (N=4, PRESCALE=4, HOLD_TICKS=2).
// Build with PWM_FADE_GAMMA_EN defined to exercise the gamma output stage instead.
module tb_pwm_fade_ctrl;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic       manual;
  logic [3:0] manual_level;
  logic [3:0] threshold;
  logic       ramp_up;
  logic       peak;

  int checks;
  int failures;
  int edge_n;
  int peak_seen;

  pwm_fade_ctrl #(
    .THRESHOLD_NBITS(4),
    .PRESCALE(4),
    .HOLD_TICKS(2)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .en(en),
    .manual(manual),
    .manual_level(manual_level),
    .threshold(threshold),
    .ramp_up(ramp_up),
    .peak(peak)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (peak === 1'b1) peak_seen++;
  end

  task automatic applyStimulus(input logic en_v, input logic manual_v, input logic [3:0] level_v);
    en           = en_v;
    manual       = manual_v;
    manual_level = level_v;
  endtask

  task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s at edge %0d: got %0d, expected %0d", tag, edge_n, observed, expected);
    end
  endtask

  // Advance to just after rising edge number target, counted from the last reset release.
  task automatic stepTo(input int target);
    repeat (target - edge_n) @(posedge clk);
    edge_n = target;
    #1;
  endtask

  task automatic releaseReset();
    rst_n  = 1'b1;
    edge_n = 0;
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    edge_n    = 0;
    peak_seen = 0;
    rst_n     = 1'b0;
`ifdef PWM_FADE_GAMMA_EN
    applyStimulus(1'b0, 1'b1, 4'd8);
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_thr", 8'(threshold), 8'd0);
    checkOutput("rst_ramp", 8'(ramp_up), 8'd0);
    checkOutput("rst_peak", 8'(peak), 8'd0);
    releaseReset();
    stepTo(1);
    checkOutput("g8_latency", 8'(threshold), 8'd0);
    stepTo(2);
    checkOutput("g8", 8'(threshold), 8'd4);
    applyStimulus(1'b0, 1'b1, 4'd15);
    stepTo(3);
    checkOutput("g15_latency", 8'(threshold), 8'd4);
    stepTo(4);
    checkOutput("g15", 8'(threshold), 8'd15);
    applyStimulus(1'b0, 1'b1, 4'd3);
    stepTo(5);
    checkOutput("g3_latency", 8'(threshold), 8'd15);
    stepTo(6);
    checkOutput("g3", 8'(threshold), 8'd0);
    applyStimulus(1'b0, 1'b1, 4'd12);
    stepTo(7);
    checkOutput("g12_latency", 8'(threshold), 8'd0);
    stepTo(8);
    checkOutput("g12", 8'(threshold), 8'd9);
    checkOutput("g_ramp", 8'(ramp_up), 8'd0);
    checkOutput("g_peak", 8'(peak), 8'd0);
`else
    applyStimulus(1'b1, 1'b0, 4'd0);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_thr", 8'(threshold), 8'd0);
    checkOutput("rst_ramp", 8'(ramp_up), 8'd0);
    checkOutput("rst_peak", 8'(peak), 8'd0);

    // Reset in the middle of a ramp.
    releaseReset();
    stepTo(1);
    checkOutput("start_ramp", 8'(ramp_up), 8'd1);
    stepTo(29);
    checkOutput("pre_rst_thr", 8'(threshold), 8'd7);
    rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_thr", 8'(threshold), 8'd0);
    checkOutput("mid_rst_ramp", 8'(ramp_up), 8'd0);
    checkOutput("mid_rst_peak", 8'(peak), 8'd0);
    repeat (2) @(posedge clk);
    #1;

    // Full breathing period from the second release.
    releaseReset();
    peak_seen = 0;
    stepTo(1);
    checkOutput("up_ramp", 8'(ramp_up), 8'd1);
    checkOutput("up_thr0", 8'(threshold), 8'd0);
    stepTo(4);
    checkOutput("up_thr0_b", 8'(threshold), 8'd0);
    stepTo(5);
    checkOutput("up_thr1", 8'(threshold), 8'd1);
    stepTo(60);
    checkOutput("up_thr14", 8'(threshold), 8'd14);
    checkOutput("up_peak0", 8'(peak), 8'd0);
    stepTo(61);
    checkOutput("top_thr", 8'(threshold), 8'd15);
    checkOutput("top_peak", 8'(peak), 8'd1);
    stepTo(62);
    checkOutput("top_peak_end", 8'(peak), 8'd0);
    checkOutput("top_thr_b", 8'(threshold), 8'd15);
    stepTo(68);
    checkOutput("hold_ramp", 8'(ramp_up), 8'd1);
    stepTo(69);
    checkOutput("down_ramp", 8'(ramp_up), 8'd0);
    checkOutput("down_thr15", 8'(threshold), 8'd15);
    stepTo(72);
    checkOutput("down_thr15_b", 8'(threshold), 8'd15);
    stepTo(73);
    checkOutput("down_thr14", 8'(threshold), 8'd14);
    stepTo(129);
    checkOutput("bottom_thr", 8'(threshold), 8'd0);
    stepTo(136);
    checkOutput("low_ramp", 8'(ramp_up), 8'd0);
    stepTo(137);
    checkOutput("reup_ramp", 8'(ramp_up), 8'd1);
    checkOutput("reup_thr0", 8'(threshold), 8'd0);
    stepTo(141);
    checkOutput("reup_thr1", 8'(threshold), 8'd1);
    checkOutput("peak_count", 8'(peak_seen), 8'd1);

    // Freeze with en low, then resume.
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    releaseReset();
    stepTo(29);
    checkOutput("frz_thr7", 8'(threshold), 8'd7);
    applyStimulus(1'b0, 1'b0, 4'd0);
    stepTo(31);
    checkOutput("frz_hold", 8'(threshold), 8'd7);
    checkOutput("frz_ramp", 8'(ramp_up), 8'd0);
    stepTo(40);
    checkOutput("frz_hold_b", 8'(threshold), 8'd7);
    applyStimulus(1'b1, 1'b0, 4'd0);
    stepTo(41);
    checkOutput("res_ramp", 8'(ramp_up), 8'd1);
    stepTo(44);
    checkOutput("res_thr7", 8'(threshold), 8'd7);
    stepTo(45);
    checkOutput("res_thr8", 8'(threshold), 8'd8);

    // Manual override.
    applyStimulus(1'b1, 1'b1, 4'd9);
    stepTo(46);
    checkOutput("man_thr9", 8'(threshold), 8'd9);
    checkOutput("man_ramp", 8'(ramp_up), 8'd0);
    stepTo(60);
    checkOutput("man_thr9_b", 8'(threshold), 8'd9);
    applyStimulus(1'b1, 1'b1, 4'd3);
    stepTo(61);
    checkOutput("man_thr3", 8'(threshold), 8'd3);
    applyStimulus(1'b1, 1'b0, 4'd3);
    stepTo(62);
    checkOutput("man_exit_ramp", 8'(ramp_up), 8'd1);
    stepTo(65);
    checkOutput("man_exit_thr3", 8'(threshold), 8'd3);
    stepTo(66);
    checkOutput("man_exit_thr4", 8'(threshold), 8'd4);

    // Start the ramp already at full scale.
    applyStimulus(1'b1, 1'b1, 4'd15);
    peak_seen = 0;
    stepTo(67);
    checkOutput("sat_load", 8'(threshold), 8'd15);
    applyStimulus(1'b1, 1'b0, 4'd15);
    stepTo(71);
    checkOutput("sat_thr_pre", 8'(threshold), 8'd15);
    checkOutput("sat_peak_pre", 8'(peak), 8'd0);
    stepTo(72);
    checkOutput("sat_thr", 8'(threshold), 8'd15);
    checkOutput("sat_peak", 8'(peak), 8'd1);
    checkOutput("sat_ramp", 8'(ramp_up), 8'd1);
    stepTo(73);
    checkOutput("sat_peak_end", 8'(peak), 8'd0);
    checkOutput("sat_thr_b", 8'(threshold), 8'd15);
    stepTo(79);
    checkOutput("sat_hold_ramp", 8'(ramp_up), 8'd1);
    stepTo(80);
    checkOutput("sat_down_ramp", 8'(ramp_up), 8'd0);
    checkOutput("sat_down_thr", 8'(threshold), 8'd15);
    stepTo(84);
    checkOutput("sat_thr14", 8'(threshold), 8'd14);
    checkOutput("sat_peak_count", 8'(peak_seen), 8'd1);
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
